// File: rtl/countdown_sequencer.sv
// MM:SS countdown sequencer: button sync/edge detect, 1 s time-base, BCD digit registers.
// Optional expired/paused display flash is enabled by defining COUNTDOWN_BLINK_EN.
module countdown_sequencer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [1:0] start_minutes,
  output logic [3:0] minutes,
  output logic [3:0] tens_seconds,
  output logic [3:0] ones_seconds,
  output logic       running,
  output logic       expired,
  output logic       tick,
  output logic       blank
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  state_t          state, state_n;
  logic [2:0]      btn_s1, btn_s2, btn_s2_d, btn_ev;
  logic            start_ev, pause_ev, clear_ev;
  logic [DW-1:0]   div;
  logic            tick_now, dec, at_one, at_zero;
  logic [3:0]      min_n, tens_n, ones_n;

  // Bit order {clear, pause, start}; edge pulse is registered so it lands 3 cycles after the press.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_s2_d <= '0;
      btn_ev   <= '0;
    end else begin
      btn_s1   <= {clear, pause, start};
      btn_s2   <= btn_s1;
      btn_s2_d <= btn_s2;
      btn_ev   <= btn_s2 & ~btn_s2_d;
    end
  end

  assign start_ev = btn_ev[0];
  assign pause_ev = btn_ev[1];
  assign clear_ev = btn_ev[2];

  assign tick_now = (state == S_RUN) && (div == DIV_MAX);
  assign at_one   = (minutes == 4'd0) && (tens_seconds == 4'd0) && (ones_seconds == 4'd1);
  assign at_zero  = (minutes == 4'd0) && (tens_seconds == 4'd0) && (ones_seconds == 4'd0);

  always_comb begin
    state_n = state;
    dec     = 1'b0;
    case (state)
      S_IDLE:    if (start_ev && (start_minutes != 2'd0)) state_n = S_RUN;
      S_RUN: begin
        if (clear_ev) state_n = S_IDLE;
        else begin
          dec = tick_now && !at_zero;
          if (tick_now && at_one) state_n = S_EXPIRED;
          else if (pause_ev)      state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (clear_ev)                 state_n = S_IDLE;
        else if (pause_ev || start_ev) state_n = S_RUN;
      end
      S_EXPIRED: if (clear_ev || start_ev) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // BCD borrow chain: ones 0->9, tens 0->5, minutes take the final borrow.
  always_comb begin
    min_n  = minutes;
    tens_n = tens_seconds;
    ones_n = ones_seconds;
    if (ones_seconds != 4'd0) ones_n = ones_seconds - 4'd1;
    else begin
      ones_n = 4'd9;
      if (tens_seconds != 4'd0) tens_n = tens_seconds - 4'd1;
      else begin
        tens_n = 4'd5;
        min_n  = minutes - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      div          <= '0;
      tick         <= 1'b0;
      running      <= 1'b0;
      expired      <= 1'b0;
      minutes      <= '0;
      tens_seconds <= '0;
      ones_seconds <= '0;
    end else begin
      state   <= state_n;
      running <= (state_n == S_RUN);
      expired <= (state_n == S_EXPIRED);
      tick    <= tick_now && !clear_ev;
      if (state == S_RUN)        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      else if (state != S_PAUSE) div <= '0;
      if (state == S_IDLE) begin
        minutes      <= {2'b00, start_minutes};
        tens_seconds <= '0;
        ones_seconds <= '0;
      end else if (dec) begin
        minutes      <= min_n;
        tens_seconds <= tens_n;
        ones_seconds <= ones_n;
      end
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int HALF = TICK_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(HALF - 1);

  logic [HW-1:0] hdiv;
  logic          blink_st;

  assign blink_st = (state_n == S_EXPIRED) || (state_n == S_PAUSE);

  // Flash restarts lit on every entry into EXPIRED/PAUSE and is dark everywhere else.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      hdiv  <= '0;
      blank <= 1'b0;
    end else if (!blink_st) begin
      hdiv  <= '0;
      blank <= 1'b0;
    end else if (state_n != state) begin
      hdiv  <= '0;
      blank <= 1'b1;
    end else if (hdiv == HALF_MAX) begin
      hdiv  <= '0;
      blank <= ~blank;
    end else begin
      hdiv  <= hdiv + 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV=4; blank checks follow COUNTDOWN_BLINK_EN.
module tb_countdown_sequencer;

  logic       clk_100MHz, reset, start, pause, clear;
  logic [1:0] start_minutes;
  logic [3:0] minutes, tens_seconds, ones_seconds;
  logic       running, expired, tick, blank;
  logic [11:0] digits;
  int n_cmp, n_err;

  assign digits = {minutes, tens_seconds, ones_seconds};

  countdown_sequencer #(.TICK_DIV(4)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .start_minutes(start_minutes), .minutes(minutes), .tens_seconds(tens_seconds),
    .ones_seconds(ones_seconds), .running(running), .expired(expired), .tick(tick), .blank(blank)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic test_reset();
    @(negedge clk_100MHz);
    n_cmp++; if ({digits, running, expired, tick, blank} !== 16'h0000) begin
      n_err++; $display("FAIL reset_hold: digits=%h run=%b exp=%b tick=%b blank=%b want 000/0/0/0/0", digits, running, expired, tick, blank); end
    reset = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h200) begin n_err++; $display("FAIL reset_idle_load: digits=%h want 200", digits); end
    n_cmp++; if ({running, expired, blank} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle_flags: run=%b exp=%b blank=%b want 0/0/0", running, expired, blank); end
  endtask

  task automatic test_count();
    start_minutes = 2'd1;
    @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h100) begin n_err++; $display("FAIL idle_switch_latency: digits=%h want 100", digits); end
    start = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL start_early: running=%b want 0", running); end
    @(negedge clk_100MHz);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_run: running=%b want 1", running); end
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if ({tick, digits} !== {1'b0, 12'h100}) begin n_err++; $display("FAIL pre_tick: tick=%b digits=%h want 0/100", tick, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if ({tick, digits} !== {1'b1, 12'h059}) begin n_err++; $display("FAIL first_tick: tick=%b digits=%h want 1/059", tick, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL tick_pulse_width: tick=%b want 0", tick); end
    start = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if ({tick, digits} !== {1'b1, 12'h058}) begin n_err++; $display("FAIL second_tick: tick=%b digits=%h want 1/058", tick, digits); end
  endtask

  // Entered right after the 0:58 tick (divider 0); pause is timed to land with the divider at 2.
  task automatic test_pause();
    int bad;
    repeat (50) @(negedge clk_100MHz);
    pause = 1'b1;
    @(negedge clk_100MHz);
    pause = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    n_cmp++; if ({running, digits} !== {1'b1, 12'h045}) begin n_err++; $display("FAIL pre_pause: run=%b digits=%h want 1/045", running, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if ({running, digits} !== {1'b0, 12'h045}) begin n_err++; $display("FAIL pause_enter: run=%b digits=%h want 0/045", running, digits); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100MHz);
      if (digits !== 12'h045 || tick !== 1'b0 || running !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pause_hold: %0d bad cycles want 0", bad); end
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    n_cmp++; if ({running, tick, digits} !== {2'b10, 12'h045}) begin
      n_err++; $display("FAIL resume: run=%b tick=%b digits=%h want 1/0/045", running, tick, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL resume_tick_early: tick=%b want 0", tick); end
    @(negedge clk_100MHz);
    n_cmp++; if ({tick, digits} !== {1'b1, 12'h044}) begin n_err++; $display("FAIL resume_tick: tick=%b digits=%h want 1/044", tick, digits); end
  endtask

  task automatic test_expire();
    logic exp_blank;
    repeat (168) @(negedge clk_100MHz);
    n_cmp++; if ({running, expired, digits} !== {2'b10, 12'h002}) begin
      n_err++; $display("FAIL at_0002: run=%b exp=%b digits=%h want 1/0/002", running, expired, digits); end
    repeat (4) @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h001) begin n_err++; $display("FAIL at_0001: digits=%h want 001", digits); end
    repeat (4) @(negedge clk_100MHz);
    n_cmp++; if ({running, expired, tick, digits} !== {3'b011, 12'h000}) begin
      n_err++; $display("FAIL expire_edge: run=%b exp=%b tick=%b digits=%h want 0/1/1/000", running, expired, tick, digits); end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk_100MHz);
`ifdef COUNTDOWN_BLINK_EN
      exp_blank = ((j % 4) < 2);
`else
      exp_blank = 1'b0;
`endif
      n_cmp++; if ({expired, blank, digits} !== {1'b1, exp_blank, 12'h000}) begin
        n_err++; $display("FAIL expired_hold[%0d]: exp=%b blank=%b digits=%h want 1/%b/000", j, expired, blank, digits, exp_blank); end
    end
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if ({running, expired, blank, digits} !== {3'b000, 12'h000}) begin
      n_err++; $display("FAIL expired_exit: run=%b exp=%b blank=%b digits=%h want 0/0/0/000", running, expired, blank, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h100) begin n_err++; $display("FAIL expired_reload: digits=%h want 100", digits); end
  endtask

  task automatic test_clear_priority();
    start_minutes = 2'd3;
    @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h300) begin n_err++; $display("FAIL idle_load_3: digits=%h want 300", digits); end
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_3: running=%b want 1", running); end
    repeat (4) @(negedge clk_100MHz);
    n_cmp++; if ({tick, digits} !== {1'b1, 12'h259}) begin n_err++; $display("FAIL tick_259: tick=%b digits=%h want 1/259", tick, digits); end
    clear = 1'b1; pause = 1'b1;
    @(negedge clk_100MHz);
    clear = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if ({running, expired, tick, blank, digits} !== {4'b0000, 12'h259}) begin
      n_err++; $display("FAIL clear_wins: run=%b exp=%b tick=%b blank=%b digits=%h want 0/0/0/0/259", running, expired, tick, blank, digits); end
    @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h300) begin n_err++; $display("FAIL clear_reload: digits=%h want 300", digits); end
  endtask

  task automatic test_zero_start();
    start_minutes = 2'd0;
    @(negedge clk_100MHz);
    n_cmp++; if (digits !== 12'h000) begin n_err++; $display("FAIL idle_load_0: digits=%h want 000", digits); end
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL zero_start_a: running=%b want 0", running); end
    repeat (4) @(negedge clk_100MHz);
    n_cmp++; if ({running, tick, digits} !== {2'b00, 12'h000}) begin
      n_err++; $display("FAIL zero_start_b: run=%b tick=%b digits=%h want 0/0/000", running, tick, digits); end
  endtask

  task automatic test_reset_midcount();
    start_minutes = 2'd2;
    @(negedge clk_100MHz);
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    repeat (5) @(negedge clk_100MHz);
    n_cmp++; if ({running, digits} !== {1'b1, 12'h159}) begin n_err++; $display("FAIL pre_reset: run=%b digits=%h want 1/159", running, digits); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({running, tick, digits} !== {2'b00, 12'h000}) begin
      n_err++; $display("FAIL async_reset: run=%b tick=%b digits=%h want 0/0/000", running, tick, digits); end
    @(negedge clk_100MHz);
    reset = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    n_cmp++; if ({running, digits} !== {1'b0, 12'h200}) begin n_err++; $display("FAIL post_reset_idle: run=%b digits=%h want 0/200", running, digits); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; start_minutes = 2'd2;
    test_reset();
    test_count();
    test_pause();
    test_expire();
    test_clear_priority();
    test_zero_start();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Run/pause/clear controller and time-base for the MM:SS countdown timer; owns the 1 Hz tick generation and the BCD minutes/tens/ones digit registers.
- Sits between the board buttons/switches and the triple seven-segment display driver.
- Replaces free-running per-digit counters with a single sequenced state machine: clean start, pause, expiry and reload behaviour.

Parameters:
- TICK_DIV, 100000000, clk_100MHz cycles per 1 s tick; must be ≥2. Benches override it to 4.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  start/resume button level, asynchronous
- pause  in  1  pause button level, asynchronous
- clear  in  1  clear/reload button level, asynchronous
- start_minutes  in  2  preset minutes (0-3), static switches
- minutes  out  4  BCD minutes digit
- tens_seconds  out  4  BCD tens-of-seconds digit (0-5)
- ones_seconds  out  4  BCD ones-of-seconds digit (0-9)
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- tick  out  1  one-cycle pulse per elapsed second (RUN only)
- blank  out  1  display blank request

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All digits 0. running/expired/tick/blank 0.
  - Divider 0. Synchroniser and edge flops 0.
- Inputs start, pause and clear each pass through a 2-FF synchroniser, then a registered rising-edge detect.
  - Edge pulse asserts 3 cycles after the input rises.
  - Holding a button produces exactly one event.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN; frozen in PAUSE; cleared in IDLE and EXPIRED.
  - tick=1 on the cycle the divider equals TICK_DIV-1, then it wraps to 0.
  - First tick after start is therefore TICK_DIV cycles after RUN entry.
- States:
  - IDLE:
    - Digits load start_minutes:00 every cycle (1-cycle latency to switch changes).
    - start event with start_minutes≠0 -> RUN.
    - start event with start_minutes=0 is ignored; stays IDLE.
  - RUN:
    - On tick, decrement MM:SS.
    - Ones 0->9 with borrow; tens 0->5 with borrow; minutes decrement on borrow from tens.
    - Tick at 0:01 -> digits 0:00 and EXPIRED on the same edge.
    - pause event -> PAUSE. clear event -> IDLE.
  - PAUSE:
    - Digits and divider hold.
    - start or pause event -> RUN; divider resumes from its held value.
    - clear event -> IDLE.
  - EXPIRED:
    - Digits 0:00, expired=1.
    - clear or start event -> IDLE; reload occurs on the following cycle.
- Priority when events coincide: clear > pause > start.
- Tick and pause in the same RUN cycle: decrement is applied, then state goes to PAUSE.
- Tick at 0:01 together with pause: EXPIRED wins.
- Tick and clear in the same cycle: clear wins; no decrement.
- Digits never underflow below 0:00. No decrement occurs outside RUN.
- running and expired are registered decodes of the state; they change in the same cycle as the state register.
- blank=0 in all states when the optional feature is absent.
- Reset asserted mid-count aborts immediately to reset values.
- Counting does not resume after reset is released; a new start event is required.

Optional Feature:
- Macro COUNTDOWN_BLINK_EN.
- When defined:
  - In EXPIRED, a separate half-second divider (TICK_DIV/2) toggles blank, starting at 1 on EXPIRED entry.
  - blank is forced 0 on exit.
  - In PAUSE, blank toggles the same way for a "paused" flash.
- When undefined: blank tied to 0; no extra divider logic.

Test Plan:
- Reset, start_minutes=2, idle 5 cycles -> digits 2:00, running=0, expired=0, blank=0.
- TICK_DIV=4, start_minutes=1, pulse start -> running=1 three cycles later; after 4 cycles tick=1 and digits 0:59; after 4 more, 0:58.
- TICK_DIV=4, run from 0:02 -> 0:01 then 0:00 with expired=1 on the same edge, running=0; further cycles leave 0:00; start event -> IDLE, next cycle digits reload 1:00.
- Pause at 0:45 with divider at 2 -> digits hold 0:45 for 100 cycles; start event -> next tick arrives 2 cycles after RUN re-entry (divider resumed).
- clear, pause and tick all land in the same cycle during RUN -> IDLE, digits not decremented, reload start_minutes:00; start with start_minutes=0 -> remains IDLE.
- COUNTDOWN_BLINK_EN, TICK_DIV=4 -> in EXPIRED, blank starts at 1 and toggles every 2 cycles; clear -> blank=0.
